// File: rtl/sprite_blitter.sv
// Sprite blitter: streams a SPRITE_W x SPRITE_H sprite from a synchronous ROM
// onto a screen at (x0, y0), clipping off-screen and transparent pixels.
module sprite_blitter #(
    parameter int         SPRITE_W    = 40,
    parameter int         SPRITE_H    = 40,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    output logic [10:0] spriteAddr,
    input  logic [2:0]  spriteData,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [14:0] screenAddr,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);
    localparam int NPIX = SPRITE_W * SPRITE_H;
    localparam int CW   = $clog2(SPRITE_W);
    localparam int RW   = $clog2(SPRITE_H);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    state_t        state, state_nx;
    logic [7:0]    x0_l;
    logic [6:0]    y0_l;
    logic [CW-1:0] col, col_d;
    logic [RW-1:0] row, row_d;
    logic          vld_d;
    logic          flush_cnt;
    logic          last_addr;
    logic [8:0]    xs;
    logic [7:0]    ys;

    assign last_addr = (spriteAddr == 11'(NPIX - 1));
    // Unclipped coordinates, one bit wider than the ports so off-screen pixels never wrap
    assign xs = {1'b0, x0_l} + 9'(col_d);
    assign ys = {1'b0, y0_l} + 8'(row_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)     state_nx = READ;
            READ:    if (last_addr) state_nx = FLUSH;
            FLUSH:   if (flush_cnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Two-stage pixel pipeline: address/counters -> ROM data cycle -> registered pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_l       <= '0;
            y0_l       <= '0;
            spriteAddr <= '0;
            col        <= '0;
            row        <= '0;
            col_d      <= '0;
            row_d      <= '0;
            vld_d      <= 1'b0;
            flush_cnt  <= 1'b0;
            x          <= '0;
            y          <= '0;
            screenAddr <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                x0_l       <= x0;
                y0_l       <= y0;
                spriteAddr <= '0;
                col        <= '0;
                row        <= '0;
            end else if (state == READ) begin
                if (last_addr) begin
                    spriteAddr <= '0;
                    col        <= '0;
                    row        <= '0;
                end else begin
                    spriteAddr <= spriteAddr + 11'd1;
                    if (col == CW'(SPRITE_W - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
            flush_cnt  <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            vld_d      <= (state == READ);
            col_d      <= col;
            row_d      <= row;
            x          <= xs[7:0];
            y          <= ys[6:0];
            screenAddr <= 15'(ys) * 15'(SCREEN_W) + 15'(xs);
            colour     <= spriteData;
            plot       <= vld_d && (spriteData != TRANSPARENT) &&
                          (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
            done       <= (state == FLUSH) && flush_cnt;
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: table of directed draws, hand-written abort/ignore
// sequences, and random-ROM draws against a per-pixel reference model.
module tb_sprite_blitter;
    localparam int SW = 40, SH = 40, SCW = 160, SCH = 120, NPIX = SW * SH;
    localparam int LAST_CYC = 1605;

    logic        clk, clk_en, reset, start;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [10:0] spriteAddr;
    logic [2:0]  spriteData;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] screenAddr;
    logic [2:0]  colour;
    logic        plot, busy, done;

    logic [2:0]  rom_mem [0:2047];
    int n_chk = 0;
    int n_fail = 0;

    sprite_blitter dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
        .spriteAddr(spriteAddr), .spriteData(spriteData), .x(x), .y(y),
        .screenAddr(screenAddr), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    always @(posedge clk) spriteData <= rom_mem[spriteAddr];

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        int mode;
        int exp_n;
        int exp_first;
        int exp_lx;
        int exp_ly;
        int exp_la;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".spriteAddr"}, int'(spriteAddr), 0);
        chk({tag, ".x"}, int'(x), 0);
        chk({tag, ".y"}, int'(y), 0);
        chk({tag, ".screenAddr"}, int'(screenAddr), 0);
        chk({tag, ".colour"}, int'(colour), 0);
        chk({tag, ".plot"}, int'(plot), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
    endtask

    // 0: all 3'b101, 1: transparent even / 3'b010 odd, 2: random, 3: all 3'b111
    task automatic load_rom(input int mode);
        for (int i = 0; i < 2048; i++) begin
            case (mode)
                0:       rom_mem[i] = 3'b101;
                1:       rom_mem[i] = (i % 2 == 1) ? 3'b010 : 3'b000;
                2:       rom_mem[i] = 3'($urandom_range(0, 7));
                default: rom_mem[i] = 3'b111;
            endcase
        end
    endtask

    // One draw; intr_c injects an ignored start, rst_c aborts with reset (0 = none)
    task automatic do_draw(input logic [7:0] ax, input logic [6:0] ay,
                           input int intr_c, input int rst_c,
                           output int nplots, output int first_a,
                           output int last_x, output int last_y, output int last_a);
        bit ep [0:LAST_CYC];
        int ex [0:LAST_CYC];
        int ey [0:LAST_CYC];
        int ea [0:LAST_CYC];
        int ec [0:LAST_CYC];
        bit aborted;
        int cend;
        for (int c = 0; c <= LAST_CYC; c++) begin
            ep[c] = 0; ex[c] = 0; ey[c] = 0; ea[c] = 0; ec[c] = 0;
        end
        for (int p = 0; p < NPIX; p++) begin
            int xx, yy, cc;
            xx = int'(ax) + p % SW;
            yy = int'(ay) + p / SW;
            cc = int'(rom_mem[p]);
            ep[p + 3] = (cc != 0) && (xx < SCW) && (yy < SCH);
            ex[p + 3] = xx; ey[p + 3] = yy; ea[p + 3] = yy * SCW + xx; ec[p + 3] = cc;
        end
        nplots = 0; first_a = -1; last_x = -1; last_y = -1; last_a = -1;
        aborted = 0;
        cend = (rst_c > 0) ? rst_c + 6 : LAST_CYC;
        @(negedge clk);
        start = 1'b1; x0 = ax; y0 = ay;
        @(posedge clk); #1;
        start = 1'b0; x0 = 8'($urandom); y0 = 7'($urandom);
        for (int c = 1; c <= cend; c++) begin
            chk("busy", int'(busy), (!aborted && c <= 1602) ? 1 : 0);
            chk("done", int'(done), (!aborted && c == 1603) ? 1 : 0);
            chk("plot", int'(plot), (!aborted && ep[c]) ? 1 : 0);
            if (!aborted && c <= NPIX) chk("spriteAddr", int'(spriteAddr), c - 1);
            if (plot && !aborted && ep[c]) begin
                chk("x", int'(x), ex[c]);
                chk("y", int'(y), ey[c]);
                chk("screenAddr", int'(screenAddr), ea[c]);
                chk("colour", int'(colour), ec[c]);
            end
            if (plot) begin
                nplots++;
                if (first_a < 0) first_a = int'(screenAddr);
                last_x = int'(x); last_y = int'(y); last_a = int'(screenAddr);
            end
            if (c == rst_c) begin
                reset = 1'b1;
                #1;
                check_zero("midreset");
                aborted = 1;
            end
            if (rst_c > 0 && c == rst_c + 1) begin start = 1'b1; x0 = 8'd0; y0 = 7'd0; end
            if (rst_c > 0 && c == rst_c + 2) start = 1'b0;
            if (rst_c > 0 && c == rst_c + 3) reset = 1'b0;
            if (c == intr_c)     begin start = 1'b1; x0 = 8'd0; y0 = 7'd0; end
            if (c == intr_c + 1) start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs [6];
    int n, fa, lx, ly, la;

    initial begin
        vecs[0] = '{8'd10,  7'd20,  0, 1600, 3210,  49,  59,  9489};
        vecs[1] = '{8'd140, 7'd100, 3, 400,  16140, 159, 119, 19199};
        vecs[2] = '{8'd0,   7'd0,   1, 800,  1,     39,  39,  6279};
        vecs[3] = '{8'd159, 7'd119, 0, 1,    19199, 159, 119, 19199};
        vecs[4] = '{8'd255, 7'd127, 0, 0,    -1,    -1,  -1,  -1};
        vecs[5] = '{8'd120, 7'd0,   3, 1600, 120,   159, 39,  6399};

        clk_en = 1'b0; reset = 1'b0; start = 1'b0; x0 = '0; y0 = '0;
        load_rom(0);
        #3 reset = 1'b1;
        #1 check_zero("reset");
        clk_en = 1'b1;
        start = 1'b1;
        #30;
        start = 1'b0;
        @(negedge clk) reset = 1'b0;
        #1;
        chk("release.busy", int'(busy), 0);
        chk("release.done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 chk("start_in_reset.busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            load_rom(vecs[i].mode);
            do_draw(vecs[i].x0, vecs[i].y0, 0, 0, n, fa, lx, ly, la);
            chk($sformatf("vec%0d.nplots", i), n, vecs[i].exp_n);
            chk($sformatf("vec%0d.first", i), fa, vecs[i].exp_first);
            chk($sformatf("vec%0d.last_x", i), lx, vecs[i].exp_lx);
            chk($sformatf("vec%0d.last_y", i), ly, vecs[i].exp_ly);
            chk($sformatf("vec%0d.last_a", i), la, vecs[i].exp_la);
        end

        // Start while busy ignored, then reset mid-draw, then a fresh draw from origin
        load_rom(0);
        do_draw(8'd10, 7'd20, 100, 0, n, fa, lx, ly, la);
        chk("ignored.nplots", n, 1600);
        chk("ignored.first", fa, 3210);
        chk("ignored.last_a", la, 9489);
        do_draw(8'd30, 7'd5, 0, 500, n, fa, lx, ly, la);
        chk("abort.nplots", n, 498);
        do_draw(8'd0, 7'd0, 0, 0, n, fa, lx, ly, la);
        chk("fresh.nplots", n, 1600);
        chk("fresh.first", fa, 0);

        for (int r = 0; r < 3; r++) begin
            load_rom(2);
            do_draw(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 0, 0, n, fa, lx, ly, la);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SPRITE_W, 40, sprite width in pixels.
REQ-002 Parameter SPRITE_H, 40, sprite height in pixels.
REQ-003 Parameter SCREEN_W, 160, screen width in pixels.
REQ-004 Parameter SCREEN_H, 120, screen height in pixels.
REQ-005 Parameter TRANSPARENT, 3'b000, colour value never plotted.
REQ-006 Clocking SHALL use one clock; reset is asynchronous and active-high.
REQ-007 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-008 Port reset  input  1  asynchronous, active-high reset.
REQ-009 Port start  input  1  single-cycle request to draw one sprite.
REQ-010 Port x0  input  8  screen column of sprite top-left pixel.
REQ-011 Port y0  input  7  screen row of sprite top-left pixel.
REQ-012 Port spriteAddr  output  11  sprite ROM read address, row-major, row*SPRITE_W+col.
REQ-013 Port spriteData  input  3  sprite ROM colour; synchronous ROM, valid the cycle after spriteAddr.
REQ-014 Port x  output  8  screen column of the emitted pixel.
REQ-015 Port y  output  7  screen row of the emitted pixel.
REQ-016 Port screenAddr  output  15  y*SCREEN_W+x of the emitted pixel.
REQ-017 Port colour  output  3  colour of the emitted pixel.
REQ-018 Port plot  output  1  write enable for the screen memory/VGA adapter.
REQ-019 Port busy  output  1  high while a sprite is being drawn.
REQ-020 Port done  output  1  single-cycle pulse when a draw completes.

Function
REQ-021 FSM SHALL have states IDLE, READ, FLUSH; IDLE -> READ on start; READ -> FLUSH after address SPRITE_W*SPRITE_H-1 issued; FLUSH -> IDLE after 2 cycles, asserting done on the cycle after the last plot slot.
REQ-022 start SHALL be accepted only in IDLE; x0, y0 latched at acceptance; start while busy ignored; later x0/y0 changes have no effect on the current draw.
REQ-023 Cycle numbering: start sampled at edge E0 = cycle 0; spriteAddr=0 in cycle 1, incrementing by 1 per cycle through 1599 in cycle 1600.
REQ-024 spriteData for the address presented in cycle n SHALL be sampled at end of cycle n+1; x, y, screenAddr, colour, plot for that pixel SHALL be registered and valid in cycle n+2.
REQ-025 busy SHALL be high cycles 1..1602, low in cycle 1603; done SHALL be high in cycle 1603 only.
REQ-026 Pixel coordinates: x = x0+col, y = y0+row, computed 9-bit/8-bit wide before clipping; no wrap-around.
REQ-027 plot SHALL be 1 only if colour != TRANSPARENT and x < SCREEN_W and y < SCREEN_H; otherwise 0 for that slot, timing unchanged.
REQ-028 screenAddr SHALL equal y*160+x for every plotted pixel (max 19199); x, y, screenAddr, colour are don't-care when plot=0.
REQ-029 Column counter SHALL wrap 0 after SPRITE_W-1 and increment row; no extra cycle at row boundaries.
REQ-030 plot SHALL be 0 in all cycles outside the window of cycles 3..1602 after accepted start.

Reset
REQ-031 reset SHALL immediately force state IDLE and all outputs to 0 (spriteAddr, x, y, screenAddr, colour, plot, busy, done), independent of clk.
REQ-032 reset mid-draw SHALL abort with no further plot and no done; a start after reset deasserts SHALL begin a fresh draw.
REQ-033 start asserted while reset is high SHALL be ignored.

Verification
REQ-034 Assert reset with no clock edge -> all outputs 0 immediately; release -> IDLE, busy=0.
REQ-035 start, x0=10, y0=20, ROM returns 3'b101 everywhere -> 1600 plots in cycles 3..1602; first x=10,y=20,screenAddr=3210; last x=49,y=59,screenAddr=9489; done=1 in cycle 1603 only.
REQ-036 start, x0=140, y0=100, opaque ROM -> exactly 400 plots (cols 0..19, rows 0..19); last plot x=159,y=119,screenAddr=19199; done still cycle 1603.
REQ-037 ROM returns TRANSPARENT at even addresses, 3'b010 at odd -> exactly 800 plots, all colour=3'b010.
REQ-038 Second start at cycle 100 with x0=0 -> ignored, coordinates still from first origin; reset at cycle 500 -> plot/busy 0, no done; new start at x0=0,y0=0 -> first plot screenAddr=0, 1600 plots.
